window_slider_3x3: RTL and testbench

- Stage directly downstream of the three-row line buffer in the CNN feature-map datapath.
- Accepts one set of three complete rows (top/mid/bot, W pixels × K channels each) per handshake.
- Slides a 3×3×K window across the columns, one window per output handshake, stride 1.
- Feeds the 3×3 convolution engine, tagging each window with row/column position and end-of-row/end-of-frame flags.

---
 rtl/cnn_pkg.sv | 18 +
 rtl/window_col_mux.sv | 31 +++
 rtl/window_slider_3x3.sv | 121 ++++++++++++
 tb/tb_window_slider_3x3.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared defaults and types for the CNN feature-map window datapath.
// The WINDOW_ZERO_PAD_EN macro is consumed by the modules importing this package.
package cnn_pkg;

    localparam int DATA_BITS_DEF = 8;
    localparam int K_DEF         = 6;
    localparam int W_DEF         = 24;
    localparam int H_DEF         = 24;

    // One pixel = K channel samples packed side by side
    localparam int PIX_BITS_DEF  = K_DEF * DATA_BITS_DEF;

    typedef enum logic {
        IDLE  = 1'b0,
        SLIDE = 1'b1
    } slide_state_t;

endpackage

// File: rtl/window_col_mux.sv
// Picks the three adjacent pixels (all K channels) of one captured row that
// start at column col. With WINDOW_ZERO_PAD_EN the window is centred on col and
// pixels falling outside the row read as zero.
module window_col_mux
    import cnn_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int K         = K_DEF,
    parameter int W         = W_DEF
) (
    input  logic [W*K*DATA_BITS-1:0] row,
    input  logic [$clog2(W)-1:0]     col,
    output logic [3*K*DATA_BITS-1:0] cols
);

    localparam int PIX = K * DATA_BITS;
    localparam int CW  = $clog2(W);
    // Two spare bits: room for col+2 and for the -1 wrap used as an out-of-range marker
    localparam int IW  = CW + 2;

    for (genvar gi = 0; gi < 3; gi++) begin : g_col
        logic [IW-1:0] idx;
`ifdef WINDOW_ZERO_PAD_EN
        assign idx = IW'(col) + IW'(gi) - IW'(1);
`else
        assign idx = IW'(col) + IW'(gi);
`endif
        assign cols[gi*PIX +: PIX] = (idx < IW'(W)) ? row[idx*PIX +: PIX] : '0;
    end

endmodule

// File: rtl/window_slider_3x3.sv
// Captures a top/mid/bot row set and slides a 3x3xK window across it, stride 1.
// Build option WINDOW_ZERO_PAD_EN: horizontal same-padding (W windows per row set).
module window_slider_3x3
    import cnn_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF,
    parameter int K         = K_DEF,
    parameter int W         = W_DEF,
    parameter int H         = H_DEF
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [W*K*DATA_BITS-1:0]   row_top_i,
    input  logic [W*K*DATA_BITS-1:0]   row_mid_i,
    input  logic [W*K*DATA_BITS-1:0]   row_bot_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [9*K*DATA_BITS-1:0]   window_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(W)-1:0]       col_o,
    output logic [$clog2(H)-1:0]       row_o,
    output logic                       last_col_o,
    output logic                       last_frame_o
);

    localparam int ROW_BITS = W * K * DATA_BITS;
    localparam int SET_BITS = 3 * K * DATA_BITS;
    localparam int CW       = $clog2(W);
    localparam int RW       = $clog2(H);

`ifdef WINDOW_ZERO_PAD_EN
    localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
`else
    localparam logic [CW-1:0] COL_LAST = CW'(W - 3);
`endif
    localparam logic [RW-1:0] ROW_LAST = RW'(H - 3);

    slide_state_t        state_reg, state_next;
    logic [CW-1:0]       col_reg, col_next;
    logic [RW-1:0]       row_reg, row_next;
    logic                capture;
    logic [ROW_BITS-1:0] top_reg, mid_reg, bot_reg;
    logic [SET_BITS-1:0] cols_top, cols_mid, cols_bot;

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (valid_i) begin
                    capture    = 1'b1;
                    col_next   = '0;
                    state_next = SLIDE;
                end
            end
            SLIDE: begin
                if (ready_i) begin
                    if (col_reg == COL_LAST) begin
                        state_next = IDLE;
                        col_next   = '0;
                        row_next   = (row_reg == ROW_LAST) ? '0 : row_reg + RW'(1);
                    end else begin
                        col_next   = col_reg + CW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            col_reg   <= '0;
            row_reg   <= '0;
            top_reg   <= '0;
            mid_reg   <= '0;
            bot_reg   <= '0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            if (capture) begin
                top_reg <= row_top_i;
                mid_reg <= row_mid_i;
                bot_reg <= row_bot_i;
            end
        end
    end

    window_col_mux #(.DATA_BITS(DATA_BITS), .K(K), .W(W)) u_mux_top (
        .row  (top_reg),
        .col  (col_reg),
        .cols (cols_top)
    );

    window_col_mux #(.DATA_BITS(DATA_BITS), .K(K), .W(W)) u_mux_mid (
        .row  (mid_reg),
        .col  (col_reg),
        .cols (cols_mid)
    );

    window_col_mux #(.DATA_BITS(DATA_BITS), .K(K), .W(W)) u_mux_bot (
        .row  (bot_reg),
        .col  (col_reg),
        .cols (cols_bot)
    );

    // Outputs depend only on captured rows and the column/row counters
    assign window_o     = {cols_bot, cols_mid, cols_top};
    assign ready_o      = (state_reg == IDLE);
    assign valid_o      = (state_reg == SLIDE);
    assign col_o        = col_reg;
    assign row_o        = row_reg;
    assign last_col_o   = (state_reg == SLIDE) && (col_reg == COL_LAST);
    assign last_frame_o = last_col_o && (row_reg == ROW_LAST);

endmodule

// File: tb/tb_window_slider_3x3.sv
// Scoreboard bench for window_slider_3x3; honours WINDOW_ZERO_PAD_EN when defined.
module tb_window_slider_3x3;
    import cnn_pkg::*;

    localparam int DB       = DATA_BITS_DEF;
    localparam int K        = K_DEF;
    localparam int W        = W_DEF;
    localparam int H        = H_DEF;
    localparam int ROWB     = W * K * DB;
    localparam int WINB     = 9 * K * DB;
    localparam int CW       = $clog2(W);
    localparam int RW       = $clog2(H);
`ifdef WINDOW_ZERO_PAD_EN
    localparam int NWIN     = W;
    localparam int XOFF     = -1;
`else
    localparam int NWIN     = W - 2;
    localparam int XOFF     = 0;
`endif

    typedef struct packed {
        logic [WINB-1:0] win;
        logic [CW-1:0]   col;
        logic [RW-1:0]   row;
        logic            lc;
        logic            lf;
    } entry_t;

    logic            clk = 1'b0;
    logic            resetn;
    logic [ROWB-1:0] row_top_i, row_mid_i, row_bot_i;
    logic            valid_i, ready_i;
    logic            ready_o, valid_o, last_col_o, last_frame_o;
    logic [WINB-1:0] window_o;
    logic [CW-1:0]   col_o;
    logic [RW-1:0]   row_o;

    entry_t          sb_q[$];
    int              tests = 0;
    int              fails = 0;
    int              exp_row = 0;
    int              lf_count = 0;
    logic [WINB-1:0] col5_win;

    always #5 clk = ~clk;

    window_slider_3x3 #(.DATA_BITS(DB), .K(K), .W(W), .H(H)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .row_top_i    (row_top_i),
        .row_mid_i    (row_mid_i),
        .row_bot_i    (row_bot_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .window_o     (window_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .col_o        (col_o),
        .row_o        (row_o),
        .last_col_o   (last_col_o),
        .last_frame_o (last_frame_o)
    );

    // Pixel model: seed 0 gives x*8+k with row offsets 0/64/128
    function automatic logic [DB-1:0] pix(int seed, int r, int x, int k);
        int v;
        v = x * 8 + k + r * 64 + seed * 3;
        return DB'(v);
    endfunction

    function automatic logic [ROWB-1:0] make_row(int seed, int r);
        logic [ROWB-1:0] v;
        v = '0;
        for (int x = 0; x < W; x++)
            for (int k = 0; k < K; k++)
                v[(x*K+k)*DB +: DB] = pix(seed, r, x, k);
        return v;
    endfunction

    function automatic logic [WINB-1:0] exp_window(int seed, int col);
        logic [WINB-1:0] v;
        int x;
        v = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                for (int k = 0; k < K; k++) begin
                    x = col + c + XOFF;
                    v[((r*3+c)*K+k)*DB +: DB] = (x < 0 || x >= W) ? '0 : pix(seed, r, x, k);
                end
        return v;
    endfunction

    task automatic push_set(int seed);
        entry_t e;
        for (int c = 0; c < NWIN; c++) begin
            e.win = exp_window(seed, c);
            e.col = CW'(c);
            e.row = RW'(exp_row);
            e.lc  = (c == NWIN - 1);
            e.lf  = (c == NWIN - 1) && (exp_row == H - 3);
            sb_q.push_back(e);
        end
        exp_row = (exp_row == H - 3) ? 0 : exp_row + 1;
    endtask

    task automatic send_set(int seed);
        int w;
        w = 0;
        while (ready_o !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (ready_o !== 1'b1) begin
            tests++; fails++;
            $display("FAIL send_wait: ready_o=%b required 1 within 100 cycles", ready_o);
        end
        row_top_i = make_row(seed, 0);
        row_mid_i = make_row(seed, 1);
        row_bot_i = make_row(seed, 2);
        valid_i   = 1'b1;
        $display("[TB] row set seed=%0d driven, expected row %0d", seed, exp_row);
        push_set(seed);
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic run_windows(int n, bit bp);
        int     got, cyc;
        bit     stalled, r;
        entry_t cur, held, e;
        got = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (got < n && cyc < n * 4 + 10) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            cur = {window_o, col_o, row_o, last_col_o, last_frame_o};
            if (stalled) begin
                tests++;
                if (cur !== held) begin
                    fails++;
                    $display("FAIL hold_stable: col=%0d row=%0d lc=%b lf=%b required col=%0d row=%0d lc=%b lf=%b",
                             cur.col, cur.row, cur.lc, cur.lf, held.col, held.row, held.lc, held.lf);
                end
            end
            r = bp ? cyc[0] : 1'b1;
            ready_i = r;
            if (valid_o === 1'b1) begin
                tests++;
                if (ready_o !== 1'b0) begin
                    fails++;
                    $display("FAIL ready_in_slide: ready_o=%b required 0", ready_o);
                end
                if (r) begin
                    if (sb_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL extra_window: col=%0d produced, required none", cur.col);
                    end else begin
                        e = sb_q.pop_front();
                        tests++;
                        if (cur.win !== e.win) begin
                            fails++;
                            $display("FAIL window_data col=%0d: got %h required %h", e.col, cur.win, e.win);
                        end
                        tests++;
                        if ({cur.col, cur.row, cur.lc, cur.lf} !== {e.col, e.row, e.lc, e.lf}) begin
                            fails++;
                            $display("FAIL window_tag: col=%0d row=%0d lc=%b lf=%b required col=%0d row=%0d lc=%b lf=%b",
                                     cur.col, cur.row, cur.lc, cur.lf, e.col, e.row, e.lc, e.lf);
                        end
                    end
                    if (cur.lf === 1'b1) lf_count++;
                    if (cur.col == CW'(5)) col5_win = cur.win;
                    got++;
                    stalled = 1'b0;
                end else begin
                    held = cur;
                    stalled = 1'b1;
                end
            end else begin
                stalled = 1'b0;
            end
        end
        if (got < n) begin
            tests++; fails++;
            $display("FAIL window_count: got %0d windows required %0d", got, n);
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        sb_q.delete();
        exp_row = 0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        row_top_i = '0; row_mid_i = '0; row_bot_i = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        tests++;
        if ({ready_o, valid_o, col_o, row_o, last_col_o, last_frame_o} !== {1'b1, 1'b0, CW'(0), RW'(0), 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: ready=%b valid=%b col=%0d row=%0d lc=%b lf=%b required 1 0 0 0 0 0",
                     ready_o, valid_o, col_o, row_o, last_col_o, last_frame_o);
        end
        tests++;
        if (window_o !== '0) begin
            fails++;
            $display("FAIL reset_window: got %h required 0", window_o);
        end
    endtask

    task automatic test_single();
        logic [DB-1:0] v120;
        send_set(0);
        tests++;
        if (valid_o !== 1'b1) begin
            fails++;
            $display("FAIL first_latency: valid_o=%b required 1", valid_o);
        end
        run_windows(NWIN, 1'b0);
        tests++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_set: ready=%b valid=%b required 1 0", ready_o, valid_o);
        end
`ifndef WINDOW_ZERO_PAD_EN
        v120 = col5_win[((1*3+2)*K+0)*DB +: DB];
        tests++;
        if (v120 !== DB'(120)) begin
            fails++;
            $display("FAIL win_1_2_0_col5: got %0d required 120", v120);
        end
`else
        v120 = col5_win[((1*3+2)*K+0)*DB +: DB];
        tests++;
        if (v120 !== DB'(112)) begin
            fails++;
            $display("FAIL win_1_2_0_col5_pad: got %0d required 112", v120);
        end
`endif
    endtask

    task automatic test_backpressure();
        send_set(1);
        run_windows(NWIN, 1'b1);
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL bp_leftover: %0d windows missing, required 0", sb_q.size());
        end
    endtask

    task automatic test_ignore_input();
        send_set(20);
        ready_i   = 1'b0;
        row_top_i = make_row(77, 0);
        row_mid_i = make_row(77, 1);
        row_bot_i = make_row(77, 2);
        valid_i   = 1'b1;
        tests++;
        if (ready_o !== 1'b0) begin
            fails++;
            $display("FAIL ready_busy: ready_o=%b required 0", ready_o);
        end
        repeat (2) @(negedge clk);
        valid_i = 1'b0;
        run_windows(NWIN, 1'b0);
    endtask

    task automatic test_reset_mid();
        send_set(5);
        run_windows(10, 1'b0);
        ready_i = 1'b0;
        tests++;
        if (col_o !== CW'(10)) begin
            fails++;
            $display("FAIL pre_reset_col: got %0d required 10", col_o);
        end
        resetn = 1'b0;
        #1;
        tests++;
        if ({valid_o, ready_o, col_o} !== {1'b0, 1'b1, CW'(0)}) begin
            fails++;
            $display("FAIL async_reset: valid=%b ready=%b col=%0d required 0 1 0", valid_o, ready_o, col_o);
        end
        sb_q.delete();
        exp_row = 0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        send_set(6);
        run_windows(NWIN, 1'b0);
    endtask

    task automatic test_full_frame();
        pulse_reset();
        lf_count = 0;
        for (int s = 0; s < H - 2; s++) begin
            send_set(s + 10);
            run_windows(NWIN, 1'b0);
        end
        tests++;
        if (lf_count != 1) begin
            fails++;
            $display("FAIL last_frame_count: got %0d required 1", lf_count);
        end
        send_set(40);
        tests++;
        if (row_o !== RW'(0)) begin
            fails++;
            $display("FAIL row_wrap: got %0d required 0", row_o);
        end
        run_windows(NWIN, 1'b0);
    endtask

    initial begin
        col5_win = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_ignore_input();
        test_reset_mid();
        test_full_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
